// File: rtl/fft_pkg.sv
// Shared types for the fft4 front-end: complex packing, Q1.15 field positions
// and the frame sequencer state encoding.
package fft_pkg;

  typedef logic [31:0] cplx_t;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } seq_state_t;

  // Real-only sample with headroom shift; imaginary part is always zero.
  function automatic cplx_t pack_real(input logic signed [15:0] s, input int shift);
    cplx_t r;
    r = '0;
    r[RE_MSB:RE_LSB] = s >>> shift;
    r[IM_MSB:IM_LSB] = '0;
    return r;
  endfunction

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank ping-pong sample buffer: write side groups samples into 4-sample
// frames, read side exposes the bank selected by the sequencer.
module frame_pingpong_buf
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [15:0]      sample_data,
  output logic             sample_ready,
  input  logic             rd_bank,
  input  logic             free_rd,
  output logic [1:0]       bank_full,
  output logic [3:0][15:0] rd_samples
);

  logic [1:0][3:0][15:0] bank_q, bank_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            wr_cnt_q, wr_cnt_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic                  accept;

  assign sample_ready = !bank_full_q[wr_bank_q];
  assign accept       = sample_valid && sample_ready;
  assign bank_full    = bank_full_q;
  assign rd_samples   = bank_q[rd_bank];

  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    bank_full_d = bank_full_q;
    if (accept) begin
      bank_d[wr_bank_q][wr_cnt_q] = sample_data;
      wr_cnt_d = wr_cnt_q + 2'd1;
      if (wr_cnt_q == 2'd3) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
      end
    end
    // The freed bank is never the one being written, so the bits never collide.
    if (free_rd) begin
      bank_full_d[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= 2'd0;
      bank_full_q <= 2'b00;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      bank_full_q <= bank_full_d;
    end
  end

endmodule

// File: rtl/fft4_frame_sequencer.sv
// Front-end scheduler for the 4-point FFT core: frames samples, runs the core
// start/done handshake and drains the four bins over valid/ready.
module fft4_frame_sequencer
  import fft_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_data,
  output logic        fft_start,
  output logic [31:0] fft_in0,
  output logic [31:0] fft_in1,
  output logic [31:0] fft_in2,
  output logic [31:0] fft_in3,
  input  logic [31:0] fft_out0,
  input  logic [31:0] fft_out1,
  input  logic [31:0] fft_out2,
  input  logic [31:0] fft_out3,
  input  logic        fft_done,
  output logic        bin_valid,
  input  logic        bin_ready,
  output logic [1:0]  bin_index,
  output logic [31:0] bin_data,
  output logic        busy
);

  seq_state_t       state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  cplx_t [3:0]      fft_in_q, fft_in_d;
  cplx_t [3:0]      res_q, res_d;
  logic             res_full_q, res_full_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             free_rd;
  logic [1:0]       bank_full;
  logic [3:0][15:0] rd_samples;

  frame_pingpong_buf u_buf (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .rd_bank      (rd_bank_q),
    .free_rd      (free_rd),
    .bank_full    (bank_full),
    .rd_samples   (rd_samples)
  );

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    fft_in_d    = fft_in_q;
    res_d       = res_q;
    res_full_d  = res_full_q;
    drain_cnt_d = drain_cnt_q;
    fft_start   = 1'b0;
    free_rd     = 1'b0;

    // Drain never overlaps a capture: RUN is only entered with res_full clear.
    if (res_full_q && bin_ready) begin
      drain_cnt_d = drain_cnt_q + 2'd1;
      if (drain_cnt_q == 2'd3) begin
        res_full_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bank_full[rd_bank_q] && !res_full_q) begin
          for (int k = 0; k < 4; k++) begin
            fft_in_d[k] = pack_real(rd_samples[k], SHIFT);
          end
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        fft_start = 1'b1;
        if (fft_done) begin
          res_d[0]   = fft_out0;
          res_d[1]   = fft_out1;
          res_d[2]   = fft_out2;
          res_d[3]   = fft_out3;
          res_full_d = 1'b1;
          free_rd    = 1'b1;
          rd_bank_d  = !rd_bank_q;
          state_d    = ST_RELEASE;
        end
      end
      // One cycle with start low lets the core fall back from DONE to RESET.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_bank_q   <= 1'b0;
      fft_in_q    <= '0;
      res_q       <= '0;
      res_full_q  <= 1'b0;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      fft_in_q    <= fft_in_d;
      res_q       <= res_d;
      res_full_q  <= res_full_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign fft_in0   = fft_in_q[0];
  assign fft_in1   = fft_in_q[1];
  assign fft_in2   = fft_in_q[2];
  assign fft_in3   = fft_in_q[3];
  assign bin_valid = res_full_q;
  assign bin_index = drain_cnt_q;
  assign bin_data  = res_full_q ? res_q[drain_cnt_q] : 32'h0;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_RELEASE);

endmodule
